grf_mp: RTL and testbench
=========================

# grf_mp

Parametrised general register file for the pipelined datapath, replacing the fixed 32×32 two-read/one-write GRF. It provides `NUM_RD` combinational read ports, one synchronous write port, an optional write-to-read bypass, and a per-register pending-write scoreboard. The decode stage uses it to read operands and detect RAW hazards, and writeback uses it to retire results. Register 0 is hardwired to zero and is never busy.

## Interface
- `DATA_W`, default 32: register width in bits.
- `ADDR_W`, default 5: address width; the file holds 2**ADDR_W registers.
- `NUM_RD`, default 2: number of read ports (1..4).
- `BYPASS`, default 1: 1 forwards a same-cycle write to the read ports; 0 makes a read return the old value.

- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `ra`  in  NUM_RD*ADDR_W  read addresses; port i uses bits [i*ADDR_W +: ADDR_W].
- `rd_data`  out  NUM_RD*DATA_W  read data; port i uses bits [i*DATA_W +: DATA_W].
- `rd_busy`  out  NUM_RD  1 when the register addressed by port i has a pending, unretired write.
- `we`  in  1  write enable.
- `wa`  in  ADDR_W  write address.
- `wd`  in  DATA_W  write data.
- `pend_set`  in  1  marks `pend_addr` busy (a producer has been issued).
- `pend_addr`  in  ADDR_W  destination register of the issued producer.
- `busy_vec`  out  2**ADDR_W  registered scoreboard; bit 0 is always 0.

## Operation
- Storage: 2**ADDR_W registers of DATA_W bits. Register 0 reads 0. A write to address 0 is discarded and changes nothing, including the scoreboard.
- Write: when `we`=1 and `wa`≠0, `regs[wa]` ← `wd` at the clock edge, and `busy[wa]` is cleared at the same edge.
- Scoreboard set: when `pend_set`=1 and `pend_addr`≠0, `busy[pend_addr]` ← 1 at the clock edge.
- Set and clear on the same address in the same cycle: the set wins and the busy bit ends at 1, because the new producer supersedes the retiring one. The data write still occurs.
- Read port i, evaluated combinationally and independently per port:
  - `ra_i`=0: `rd_data_i`=0 and `rd_busy_i`=0.
  - `BYPASS`=1, `we`=1, `wa`=`ra_i`≠0: `rd_data_i`=`wd` and `rd_busy_i`=0.
  - Otherwise: `rd_data_i`=`regs[ra_i]` and `rd_busy_i`=`busy[ra_i]`.
- Several ports may read the same address in the same cycle; each returns an identical result.
- Reset (`reset`=0 at a clock edge): every register ← 0 and every busy bit ← 0. Reset overrides `we` and `pend_set` in that cycle. Reset applied mid-stream discards all pending state.

## Timing
- Read latency is 0 cycles (combinational from `ra`, `we`, `wa`, `wd` and the state).
- A write is visible to reads in the cycle after the edge. With `BYPASS`=1 it is also visible in the same cycle.
- A busy bit becomes visible on `rd_busy` and `busy_vec` one cycle after `pend_set`. It drops one cycle after the write edge, or in the same cycle via bypass.
- Output values after reset: `busy_vec`=0. `rd_data` reads 0 and `rd_busy` reads 0 for any address, until the first write.
- During reset the read outputs follow the state at that moment. They are guaranteed valid only from the first cycle after `reset` returns high.

## Test plan
- Reset, then write 1234 to reg 1 and read ports (ra0=1, ra1=12) on the next cycle → rd_data0=1234, rd_data1=0.
- `BYPASS`=1: in one cycle set we=1, wa=13, wd=0xDEADBEEF, ra0=13 → rd_data0=0xDEADBEEF in that same cycle. Repeat with `BYPASS`=0 → the old value 0 is returned, and 0xDEADBEEF appears the next cycle.
- Write wa=0, wd=0xFFFFFFFF, then read ra0=0 → rd_data0=0, rd_busy0=0, busy_vec[0]=0.
- Scoreboard sequence:
  - pend_set on reg 5 at cycle n → rd_busy=1 for ra=5 at cycle n+1.
  - Write reg 5 at cycle n+3 → with `BYPASS`=1, rd_busy=0 in cycle n+3; busy_vec[5]=0 from n+4.
- Same-cycle pend_set(7) and we(7, wd=42) → busy_vec[7]=1 and regs[7]=42 after the edge.
- Load regs 1..31 with distinct values and set several busy bits, then pull `reset` low for one cycle while we=1 and pend_set=1 → every read returns 0, busy_vec=0, and the write is not performed.

Source files
------------

// File: rtl/grf_mp.sv
// Parametrised register file: NUM_RD combinational read ports, one write port,
// optional write-to-read bypass and a per-register pending-write scoreboard.
module grf_mp #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned NUM_RD = 2,
  parameter int unsigned BYPASS = 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_RD*ADDR_W-1:0]   ra,
  output logic [NUM_RD*DATA_W-1:0]   rd_data,
  output logic [NUM_RD-1:0]          rd_busy,
  input  logic                       we,
  input  logic [ADDR_W-1:0]          wa,
  input  logic [DATA_W-1:0]          wd,
  input  logic                       pend_set,
  input  logic [ADDR_W-1:0]          pend_addr,
  output logic [(2**ADDR_W)-1:0]     busy_vec
);

  localparam int unsigned NUM_REGS = 2 ** ADDR_W;

  logic [DATA_W-1:0]   regs [NUM_REGS];
  logic [NUM_REGS-1:0] busy;
  logic [NUM_REGS-1:0] busy_nxt;
  logic                wr_ok;
  logic                set_ok;

  assign wr_ok  = we && (wa != '0);
  assign set_ok = pend_set && (pend_addr != '0);

  // Retiring write clears, issuing producer sets; set is applied last so it wins.
  always_comb begin
    busy_nxt = busy;
    if (wr_ok) begin
      busy_nxt[wa] = 1'b0;
    end
    if (set_ok) begin
      busy_nxt[pend_addr] = 1'b1;
    end
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
      busy <= '0;
    end else begin
      if (wr_ok) begin
        regs[wa] <= wd;
      end
      busy <= busy_nxt;
    end
  end

  assign busy_vec = busy;

  // Independent read ports; register 0 always reads zero and is never busy.
  for (genvar p = 0; p < int'(NUM_RD); p++) begin : g_rd
    logic [ADDR_W-1:0] addr;
    logic              hit;
    logic [DATA_W-1:0] data;
    logic              bsy;

    assign addr = ra[p*ADDR_W +: ADDR_W];
    assign hit  = (BYPASS != 0) && we && (wa == addr);

    always_comb begin
      data = regs[addr];
      bsy  = busy[addr];
      if (addr == '0) begin
        data = '0;
        bsy  = 1'b0;
      end else if (hit) begin
        data = wd;
        bsy  = 1'b0;
      end
    end

    assign rd_data[p*DATA_W +: DATA_W] = data;
    assign rd_busy[p]                  = bsy;
  end

endmodule

// File: tb/tb_grf_mp.sv
// Bench for grf_mp: bypass and non-bypass instances share stimulus and are
// checked against an array model, with directed scenarios then random traffic.
module tb_grf_mp;

  logic        clk = 1'b0;
  logic        reset;
  logic [9:0]  ra;
  logic        we;
  logic [4:0]  wa;
  logic [31:0] wd;
  logic        pend_set;
  logic [4:0]  pend_addr;

  logic [63:0] rd_data_b, rd_data_n;
  logic [1:0]  rd_busy_b, rd_busy_n;
  logic [31:0] busy_vec_b, busy_vec_n;

  int total = 0;
  int bad   = 0;

  logic [31:0] m_regs [32];
  logic        m_busy [32];

  grf_mp #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .BYPASS(1)) dut (
    .clk(clk), .reset(reset), .ra(ra), .rd_data(rd_data_b), .rd_busy(rd_busy_b),
    .we(we), .wa(wa), .wd(wd), .pend_set(pend_set), .pend_addr(pend_addr),
    .busy_vec(busy_vec_b)
  );

  grf_mp #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .BYPASS(0)) dut_nb (
    .clk(clk), .reset(reset), .ra(ra), .rd_data(rd_data_n), .rd_busy(rd_busy_n),
    .we(we), .wa(wa), .wd(wd), .pend_set(pend_set), .pend_addr(pend_addr),
    .busy_vec(busy_vec_n)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic r, input logic [4:0] a0, input logic [4:0] a1,
                       input logic w, input logic [4:0] waddr, input logic [31:0] wdata,
                       input logic ps, input logic [4:0] pa);
    reset     = r;
    ra        = {a1, a0};
    we        = w;
    wa        = waddr;
    wd        = wdata;
    pend_set  = ps;
    pend_addr = pa;
    #1;
  endtask

  function automatic logic [32:0] model_read(input logic [4:0] a, input bit bypass);
    if (a == 5'd0) return 33'd0;
    if (bypass && we && wa == a) return {1'b0, wd};
    return {m_busy[a], m_regs[a]};
  endfunction

  function automatic logic [31:0] model_vec();
    logic [31:0] v;
    for (int i = 0; i < 32; i++) v[i] = m_busy[i];
    return v;
  endfunction

  // Compare every output against the model, then advance the model at the edge.
  task automatic tick();
    logic [32:0] e;
    logic [4:0]  a;
    @(negedge clk);
    check("busy_vec_b", 64'(busy_vec_b), 64'(model_vec()));
    check("busy_vec_n", 64'(busy_vec_n), 64'(model_vec()));
    if (reset) begin
      for (int p = 0; p < 2; p++) begin
        a = ra[p*5 +: 5];
        e = model_read(a, 1'b1);
        check($sformatf("rd_data_b%0d a=%0d", p, a), 64'(rd_data_b[p*32 +: 32]), 64'(e[31:0]));
        check($sformatf("rd_busy_b%0d a=%0d", p, a), 64'(rd_busy_b[p]), 64'(e[32]));
        e = model_read(a, 1'b0);
        check($sformatf("rd_data_n%0d a=%0d", p, a), 64'(rd_data_n[p*32 +: 32]), 64'(e[31:0]));
        check($sformatf("rd_busy_n%0d a=%0d", p, a), 64'(rd_busy_n[p]), 64'(e[32]));
      end
    end
    @(posedge clk);
    if (!reset) begin
      for (int i = 0; i < 32; i++) begin
        m_regs[i] = '0;
        m_busy[i] = 1'b0;
      end
    end else begin
      if (we && wa != 5'd0) begin
        m_regs[wa] = wd;
        m_busy[wa] = 1'b0;
      end
      if (pend_set && pend_addr != 5'd0) m_busy[pend_addr] = 1'b1;
    end
    #1;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) begin
      m_regs[i] = '0;
      m_busy[i] = 1'b0;
    end
    drive(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
    @(posedge clk);
    #1;
    tick();

    // Post-reset state
    drive(1'b1, 5'd31, 5'd17, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
    check("rst_busy_vec", 64'(busy_vec_b), 64'd0);
    check("rst_rd31", 64'(rd_data_b[31:0]), 64'd0);
    check("rst_busy31", 64'(rd_busy_b[0]), 64'd0);
    tick();

    // Write 1234 to reg 1, read it back next cycle
    drive(1'b1, 5'd2, 5'd3, 1'b1, 5'd1, 32'd1234, 1'b0, 5'd0);
    tick();
    drive(1'b1, 5'd1, 5'd12, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
    check("wr1_rd0", 64'(rd_data_b[31:0]), 64'd1234);
    check("wr1_rd1", 64'(rd_data_b[63:32]), 64'd0);
    tick();

    // Same-cycle bypass vs old value
    drive(1'b1, 5'd13, 5'd1, 1'b1, 5'd13, 32'hDEADBEEF, 1'b0, 5'd0);
    check("byp_same", 64'(rd_data_b[31:0]), 64'hDEADBEEF);
    check("nobyp_same", 64'(rd_data_n[31:0]), 64'd0);
    tick();
    drive(1'b1, 5'd13, 5'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
    check("nobyp_next", 64'(rd_data_n[31:0]), 64'hDEADBEEF);
    tick();

    // Write to reg 0 is discarded
    drive(1'b1, 5'd0, 5'd0, 1'b1, 5'd0, 32'hFFFFFFFF, 1'b0, 5'd0);
    tick();
    drive(1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
    check("r0_data", 64'(rd_data_b[31:0]), 64'd0);
    check("r0_busy", 64'(rd_busy_b[0]), 64'd0);
    check("r0_vec", 64'(busy_vec_b[0]), 64'd0);
    tick();

    // Scoreboard: set at n, visible n+1, write at n+3
    drive(1'b1, 5'd5, 5'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd5);
    tick();
    drive(1'b1, 5'd5, 5'd5, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
    check("sb_n1", 64'(rd_busy_b[0]), 64'd1);
    tick();
    tick();
    drive(1'b1, 5'd5, 5'd0, 1'b1, 5'd5, 32'h55, 1'b0, 5'd0);
    check("sb_n3_byp", 64'(rd_busy_b[0]), 64'd0);
    check("sb_n3_nobyp", 64'(rd_busy_n[0]), 64'd1);
    tick();
    drive(1'b1, 5'd5, 5'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
    check("sb_n4_vec", 64'(busy_vec_b[5]), 64'd0);
    tick();

    // Set and clear same address: set wins, data still written
    drive(1'b1, 5'd7, 5'd0, 1'b1, 5'd7, 32'd42, 1'b1, 5'd7);
    tick();
    drive(1'b1, 5'd7, 5'd7, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
    check("sc_vec7", 64'(busy_vec_b[7]), 64'd1);
    check("sc_data7", 64'(rd_data_b[31:0]), 64'd42);
    check("sc_busy7", 64'(rd_busy_b[1]), 64'd1);
    tick();

    // Fill all registers, mark some busy, then reset mid-stream
    for (int i = 1; i < 32; i++) begin
      drive(1'b1, 5'(i), 5'(i - 1), 1'b1, 5'(i), 32'h1000_0000 + 32'(i * 257),
            1'b1, 5'((i * 7) % 32));
      tick();
    end
    drive(1'b0, 5'd9, 5'd3, 1'b1, 5'd9, 32'hCAFE, 1'b1, 5'd9);
    tick();
    for (int i = 0; i < 32; i += 2) begin
      drive(1'b1, 5'(i), 5'(i + 1), 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
      check($sformatf("prst_rd%0d", i), 64'(rd_data_b[31:0]), 64'd0);
      check($sformatf("prst_rd%0d", i + 1), 64'(rd_data_b[63:32]), 64'd0);
      check("prst_vec", 64'(busy_vec_b), 64'd0);
      tick();
    end

    // Random traffic
    for (int c = 0; c < 600; c++) begin
      drive(($urandom_range(0, 59) != 0), 5'($urandom), 5'($urandom),
            1'($urandom), 5'($urandom), $urandom, 1'($urandom), 5'($urandom));
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
